// File: rtl/run_length_detector.sv
// Serial run-length detector: flags RUN_LEN identical consecutive samples of w,
// with sticky or pulse (non-overlapping) detection and a saturating event counter.
module run_length_detector #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 4,
    parameter int EVT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             w,
    input  logic             mode,
    input  logic             clear_events,
    output logic             z,
    output logic             z_ones,
    output logic             z_zeros,
    output logic             last_bit,
    output logic [CNT_W-1:0] run_len,
    output logic [EVT_W-1:0] event_count
);

    localparam logic [CNT_W-1:0] RUN_MAX    = '1;
    localparam logic [CNT_W-1:0] RUN_TARGET = CNT_W'(RUN_LEN);
    localparam logic [EVT_W-1:0] EVT_MAX    = '1;

    logic             valid_reg,       valid_next;
    logic             mode_reg,        mode_next;
    logic             last_bit_reg,    last_bit_next;
    logic [CNT_W-1:0] run_len_reg,     run_len_next;
    logic             z_reg,           z_next;
    logic             z_ones_reg,      z_ones_next;
    logic             z_zeros_reg,     z_zeros_next;
    logic [EVT_W-1:0] event_count_reg, event_count_next;
    logic [CNT_W-1:0] run_inc;
    logic             detect;

    always_comb begin
        valid_next    = valid_reg;
        mode_next     = mode_reg;
        last_bit_next = last_bit_reg;
        run_len_next  = run_len_reg;
        z_next        = z_reg;
        detect        = 1'b0;
        run_inc       = (run_len_reg == RUN_MAX) ? run_len_reg : run_len_reg + 1'b1;

        if (mode != mode_reg) begin
            // A mode switch restarts detection and discards this edge's sample.
            mode_next    = mode;
            valid_next   = 1'b0;
            run_len_next = '0;
            z_next       = 1'b0;
        end else if (enable) begin
            if (!valid_reg || (w != last_bit_reg)) begin
                run_len_next  = CNT_W'(1);
                last_bit_next = w;
                valid_next    = 1'b1;
                z_next        = 1'b0;
            end else if (mode_reg) begin
                if (run_inc == RUN_TARGET) begin
                    detect       = 1'b1;
                    run_len_next = '0;
                    z_next       = 1'b1;
                end else begin
                    run_len_next = run_inc;
                    z_next       = 1'b0;
                end
            end else begin
                run_len_next = run_inc;
                detect       = (run_inc == RUN_TARGET);
                z_next       = (run_inc >= RUN_TARGET);
            end
        end else if (mode_reg) begin
            z_next = 1'b0;
        end

        z_ones_next  = z_next & last_bit_next;
        z_zeros_next = z_next & ~last_bit_next;

        if (clear_events) begin
            event_count_next = '0;
        end else if (detect && (event_count_reg != EVT_MAX)) begin
            event_count_next = event_count_reg + 1'b1;
        end else begin
            event_count_next = event_count_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_reg       <= 1'b0;
            mode_reg        <= mode;
            last_bit_reg    <= 1'b0;
            run_len_reg     <= '0;
            z_reg           <= 1'b0;
            z_ones_reg      <= 1'b0;
            z_zeros_reg     <= 1'b0;
            event_count_reg <= '0;
        end else begin
            valid_reg       <= valid_next;
            mode_reg        <= mode_next;
            last_bit_reg    <= last_bit_next;
            run_len_reg     <= run_len_next;
            z_reg           <= z_next;
            z_ones_reg      <= z_ones_next;
            z_zeros_reg     <= z_zeros_next;
            event_count_reg <= event_count_next;
        end
    end

    assign z           = z_reg;
    assign z_ones      = z_ones_reg;
    assign z_zeros     = z_zeros_reg;
    assign last_bit    = last_bit_reg;
    assign run_len     = run_len_reg;
    assign event_count = event_count_reg;

endmodule

// File: tb/tb_run_length_detector.sv
// Directed checks of run_length_detector; a second instance with narrow counters
// shares the same stimulus to exercise saturation.
module tb_run_length_detector;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       w = 1'b0;
    logic       mode = 1'b0;
    logic       clear_events = 1'b0;

    logic       z, z_ones, z_zeros, last_bit;
    logic [3:0] run_len;
    logic [7:0] event_count;

    logic       s_z, s_z_ones, s_z_zeros, s_last_bit;
    logic [2:0] s_run_len;
    logic [1:0] s_event_count;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    run_length_detector #(.RUN_LEN(4), .CNT_W(4), .EVT_W(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .w(w), .mode(mode),
        .clear_events(clear_events), .z(z), .z_ones(z_ones), .z_zeros(z_zeros),
        .last_bit(last_bit), .run_len(run_len), .event_count(event_count)
    );

    run_length_detector #(.RUN_LEN(4), .CNT_W(3), .EVT_W(2)) dut_s (
        .clock(clock), .reset(reset), .enable(enable), .w(w), .mode(mode),
        .clear_events(clear_events), .z(s_z), .z_ones(s_z_ones), .z_zeros(s_z_zeros),
        .last_bit(s_last_bit), .run_len(s_run_len), .event_count(s_event_count)
    );

    task automatic tick(input logic en, input logic b);
        enable = en;
        w      = b;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic m);
        reset = 1'b1; mode = m; clear_events = 1'b0;
        tick(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 1'b0; clear_events = 1'b1;
        tick(1'b1, 1'b1);
        reset = 1'b0; clear_events = 1'b0;
        checks++; if (z !== 1'b0) $display("FAIL reset z: got %b want 0", z); else passed++;
        checks++; if (z_ones !== 1'b0) $display("FAIL reset z_ones: got %b want 0", z_ones); else passed++;
        checks++; if (z_zeros !== 1'b0) $display("FAIL reset z_zeros: got %b want 0", z_zeros); else passed++;
        checks++; if (last_bit !== 1'b0) $display("FAIL reset last_bit: got %b want 0", last_bit); else passed++;
        checks++; if (run_len !== 4'd0) $display("FAIL reset run_len: got %0d want 0", run_len); else passed++;
        checks++; if (event_count !== 8'd0) $display("FAIL reset event_count: got %0d want 0", event_count); else passed++;
        checks++; if (s_run_len !== 3'd0) $display("FAIL reset s_run_len: got %0d want 0", s_run_len); else passed++;
        $display("test_reset done");
    endtask

    task automatic test_sticky_zeros();
        int         exp_rl[5] = '{1, 2, 3, 4, 5};
        logic       exp_z[5]  = '{0, 0, 0, 1, 1};
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0);
            checks++; if (run_len !== 4'(exp_rl[i])) $display("FAIL sticky_zeros run_len step %0d: got %0d want %0d", i, run_len, exp_rl[i]); else passed++;
            checks++; if (z !== exp_z[i]) $display("FAIL sticky_zeros z step %0d: got %b want %b", i, z, exp_z[i]); else passed++;
            checks++; if (z_zeros !== exp_z[i]) $display("FAIL sticky_zeros z_zeros step %0d: got %b want %b", i, z_zeros, exp_z[i]); else passed++;
            checks++; if (z_ones !== 1'b0) $display("FAIL sticky_zeros z_ones step %0d: got %b want 0", i, z_ones); else passed++;
            checks++; if (event_count !== 8'(i >= 3 ? 1 : 0)) $display("FAIL sticky_zeros event_count step %0d: got %0d want %0d", i, event_count, (i >= 3 ? 1 : 0)); else passed++;
            $display("sticky_zeros sample %0d: run_len=%0d z=%b events=%0d", i, run_len, z, event_count);
        end
        tick(1'b0, 1'b1);
        checks++; if (z !== 1'b1) $display("FAIL sticky_zeros idle z: got %b want 1", z); else passed++;
        checks++; if (run_len !== 4'd5) $display("FAIL sticky_zeros idle run_len: got %0d want 5", run_len); else passed++;
    endtask

    task automatic test_sticky_mixed();
        logic bits[8]   = '{1, 1, 1, 0, 1, 1, 1, 1};
        int   exp_rl[8] = '{1, 2, 3, 1, 1, 2, 3, 4};
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, bits[i]);
            checks++; if (run_len !== 4'(exp_rl[i])) $display("FAIL sticky_mixed run_len step %0d: got %0d want %0d", i, run_len, exp_rl[i]); else passed++;
            checks++; if (z !== (i == 7)) $display("FAIL sticky_mixed z step %0d: got %b want %b", i, z, (i == 7)); else passed++;
            $display("sticky_mixed sample %0d w=%b: run_len=%0d z=%b", i, bits[i], run_len, z);
        end
        checks++; if (z_ones !== 1'b1) $display("FAIL sticky_mixed z_ones: got %b want 1", z_ones); else passed++;
        checks++; if (z_zeros !== 1'b0) $display("FAIL sticky_mixed z_zeros: got %b want 0", z_zeros); else passed++;
        checks++; if (event_count !== 8'd1) $display("FAIL sticky_mixed event_count: got %0d want 1", event_count); else passed++;
    endtask

    task automatic test_pulse();
        int   exp_rl[9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
        logic exp_z[9]  = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
        do_reset(1'b1);
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, 1'b1);
            checks++; if (run_len !== 4'(exp_rl[i])) $display("FAIL pulse run_len step %0d: got %0d want %0d", i, run_len, exp_rl[i]); else passed++;
            checks++; if (z !== exp_z[i]) $display("FAIL pulse z step %0d: got %b want %b", i, z, exp_z[i]); else passed++;
            checks++; if (z_ones !== exp_z[i]) $display("FAIL pulse z_ones step %0d: got %b want %b", i, z_ones, exp_z[i]); else passed++;
            $display("pulse sample %0d: run_len=%0d z=%b events=%0d", i, run_len, z, event_count);
        end
        checks++; if (event_count !== 8'd2) $display("FAIL pulse event_count: got %0d want 2", event_count); else passed++;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        checks++; if (z !== 1'b1) $display("FAIL pulse third z: got %b want 1", z); else passed++;
        tick(1'b0, 1'b1);
        checks++; if (z !== 1'b0) $display("FAIL pulse idle z: got %b want 0", z); else passed++;
        checks++; if (run_len !== 4'd0) $display("FAIL pulse idle run_len: got %0d want 0", run_len); else passed++;
        checks++; if (event_count !== 8'd3) $display("FAIL pulse idle event_count: got %0d want 3", event_count); else passed++;
    endtask

    task automatic test_saturate();
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0);
            checks++; if (s_run_len !== 3'((i + 1) > 7 ? 7 : (i + 1))) $display("FAIL saturate s_run_len step %0d: got %0d want %0d", i, s_run_len, ((i + 1) > 7 ? 7 : (i + 1))); else passed++;
            checks++; if (s_z !== (i >= 3)) $display("FAIL saturate s_z step %0d: got %b want %b", i, s_z, (i >= 3)); else passed++;
            $display("saturate sample %0d: s_run_len=%0d s_z=%b", i, s_run_len, s_z);
        end
        checks++; if (run_len !== 4'd10) $display("FAIL saturate run_len: got %0d want 10", run_len); else passed++;
        checks++; if (s_event_count !== 2'd1) $display("FAIL saturate s_event_count: got %0d want 1", s_event_count); else passed++;
        mode = 1'b1;
        tick(1'b1, 1'b1);
        checks++; if (s_run_len !== 3'd0) $display("FAIL mode_change s_run_len: got %0d want 0", s_run_len); else passed++;
        checks++; if (s_z !== 1'b0) $display("FAIL mode_change s_z: got %b want 0", s_z); else passed++;
        checks++; if (s_z_zeros !== 1'b0) $display("FAIL mode_change s_z_zeros: got %b want 0", s_z_zeros); else passed++;
        checks++; if (s_last_bit !== 1'b0) $display("FAIL mode_change s_last_bit: got %b want 0", s_last_bit); else passed++;
        checks++; if (s_event_count !== 2'd1) $display("FAIL mode_change s_event_count: got %0d want 1", s_event_count); else passed++;
        tick(1'b1, 1'b1);
        checks++; if (s_run_len !== 3'd1) $display("FAIL mode_change restart s_run_len: got %0d want 1", s_run_len); else passed++;
    endtask

    task automatic test_event_sat();
        do_reset(1'b1);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1);
        checks++; if (s_event_count !== 2'd3) $display("FAIL event_sat s_event_count: got %0d want 3", s_event_count); else passed++;
        checks++; if (event_count !== 8'd5) $display("FAIL event_sat event_count: got %0d want 5", event_count); else passed++;
        checks++; if (s_z !== 1'b1) $display("FAIL event_sat s_z: got %b want 1", s_z); else passed++;
        $display("event_sat after 20 ones: s_events=%0d events=%0d", s_event_count, event_count);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        clear_events = 1'b1;
        tick(1'b1, 1'b1);
        clear_events = 1'b0;
        checks++; if (s_event_count !== 2'd0) $display("FAIL clear s_event_count: got %0d want 0", s_event_count); else passed++;
        checks++; if (event_count !== 8'd0) $display("FAIL clear event_count: got %0d want 0", event_count); else passed++;
        checks++; if (s_z !== 1'b1) $display("FAIL clear s_z: got %b want 1", s_z); else passed++;
        tick(1'b1, 1'b1);
        checks++; if (z !== 1'b0) $display("FAIL clear next z: got %b want 0", z); else passed++;
        checks++; if (event_count !== 8'd0) $display("FAIL clear next event_count: got %0d want 0", event_count); else passed++;
        $display("event_sat clear: s_events=%0d events=%0d", s_event_count, event_count);
    endtask

    task automatic test_reset_mid_run();
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        reset = 1'b1;
        tick(1'b1, 1'b1);
        reset = 1'b0;
        checks++; if (run_len !== 4'd0) $display("FAIL mid_reset run_len: got %0d want 0", run_len); else passed++;
        checks++; if (last_bit !== 1'b0) $display("FAIL mid_reset last_bit: got %b want 0", last_bit); else passed++;
        checks++; if (z !== 1'b0) $display("FAIL mid_reset z: got %b want 0", z); else passed++;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1);
            checks++; if (run_len !== 4'(i + 1)) $display("FAIL mid_reset run_len step %0d: got %0d want %0d", i, run_len, i + 1); else passed++;
            checks++; if (z !== (i == 3)) $display("FAIL mid_reset z step %0d: got %b want %b", i, z, (i == 3)); else passed++;
            $display("mid_reset sample %0d: run_len=%0d z=%b", i, run_len, z);
        end
    endtask

    task automatic test_enable_gaps();
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1);
            tick(1'b0, 1'b0);
            checks++; if (run_len !== 4'(i + 1)) $display("FAIL gaps run_len step %0d: got %0d want %0d", i, run_len, i + 1); else passed++;
            checks++; if (z !== (i == 3)) $display("FAIL gaps z step %0d: got %b want %b", i, z, (i == 3)); else passed++;
            $display("gaps sample %0d: run_len=%0d z=%b", i, run_len, z);
        end
        tick(1'b1, 1'b0);
        checks++; if (z !== 1'b0) $display("FAIL gaps break z: got %b want 0", z); else passed++;
        checks++; if (run_len !== 4'd1) $display("FAIL gaps break run_len: got %0d want 1", run_len); else passed++;
        checks++; if (last_bit !== 1'b0) $display("FAIL gaps break last_bit: got %b want 0", last_bit); else passed++;
        checks++; if (z_ones !== 1'b0) $display("FAIL gaps break z_ones: got %b want 0", z_ones); else passed++;
    endtask

    initial begin
        test_reset();
        test_sticky_zeros();
        test_sticky_mixed();
        test_pulse();
        test_saturate();
        test_event_sat();
        test_reset_mid_run();
        test_enable_gaps();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/run_length_detector.md
# run_length_detector

Parametrised successor to the lab FSM sequence detector: samples a serial bit `w` on qualified clock edges and flags runs of `RUN_LEN` identical consecutive bits (all-0 or all-1). Adds a configurable run length, a per-polarity hit indication, a visible saturating run-length count, a sticky/pulse mode and a saturating detection-event counter. Sits between the switch/key input conditioning and the LEDR/HEX display logic of the lab top level.

## Interface
- `RUN_LEN`, 4: run length that constitutes a detection; legal range ≥ 2.
- `CNT_W`, 4: width of `run_len`; must satisfy 2^CNT_W − 1 ≥ `RUN_LEN`.
- `EVT_W`, 8: width of `event_count`.

Ports:
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; one clock; overrides all other inputs.
- `enable`  in  1  sample strobe; `w` is consumed only on edges where `enable`=1.
- `w`  in  1  serial data bit.
- `mode`  in  1  0 = sticky, 1 = pulse / non-overlapping.
- `clear_events`  in  1  synchronous clear of `event_count`.
- `z`  out  1  detection flag.
- `z_ones`  out  1  `z` & (`last_bit`=1).
- `z_zeros`  out  1  `z` & (`last_bit`=0).
- `last_bit`  out  1  most recently sampled bit.
- `run_len`  out  CNT_W  current run length, saturating.
- `event_count`  out  EVT_W  number of detection events, saturating.

## Operation
- Internal registers: `valid` (any sample taken since reset/mode change), `mode_q` (registered mode), plus all outputs.
- Reset: `valid`=0, `run_len`=0, `last_bit`=0, `z`=`z_ones`=`z_zeros`=0, `event_count`=0, `mode_q`=`mode`.
- Mode change: on any edge where `mode` ≠ `mode_q` (and not reset), `mode_q`←`mode`, `valid`←0, `run_len`←0, `z`←0; `event_count` retained; the sample on that edge is discarded.
- Sample (`enable`=1, no reset, no mode change):
  - If `valid`=0 or `w` ≠ `last_bit`: `run_len`←1, `last_bit`←`w`, `valid`←1.
  - Else: `n` = `run_len`+1, saturating at 2^CNT_W−1.
  - Sticky mode: `run_len`←`n`; detection event when `n` = `RUN_LEN` exactly. `z`=1 whenever `valid` and `run_len` ≥ `RUN_LEN`; held through edges with `enable`=0; cleared by the first differing bit.
  - Pulse mode: when `n` = `RUN_LEN`: detection event, `run_len`←0, `last_bit` and `valid` kept; the next equal bit restarts the count at 1. Otherwise `run_len`←`n`. `z`=1 for exactly one clock after each detection event, else 0, regardless of `enable`.
- `z_ones`/`z_zeros` are registered alongside `z` from the new `last_bit`; they are mutually exclusive.
- `event_count`: +1 per detection event, saturating at 2^EVT_W−1. `clear_events` forces it to 0 and wins over a coincident event.
- With `RUN_LEN`=4 in sticky mode, `z` matches the existing four-in-a-row detector.

## Timing
- All outputs are registered; one-clock latency from a sampling edge to `run_len`/`last_bit`/`z`/`event_count`.
- Priority: `reset` > mode change > sample > idle (hold).
- `enable`=0: every register holds, except that in pulse mode `z` returns to 0.
- Back-to-back `enable` on every clock is supported; no throughput limit.
- Reset mid-run: the run is abandoned, and the next sample starts at `run_len`=1.

## Test plan
- Reset, then `w`=0 on 4 consecutive enables, sticky mode → `run_len` 1, 2, 3, 4; `z`=`z_zeros`=1 after the 4th; `event_count`=1; a 5th 0 gives `run_len`=5, `z` stays 1, count stays 1.
- Sticky mode, 1,1,1,0,1,1,1,1 → `z` low until the 8th sample, then `z_ones`=1; `run_len`=4; `event_count`=1.
- Pulse mode, 9 consecutive 1s → `z` pulses one clock after samples 4 and 8; `run_len` reaches 0 after each; `event_count`=2; `run_len`=1 after the 9th.
- `CNT_W`=3, `RUN_LEN`=4, sticky mode, 10 equal bits → `run_len` saturates at 7 and `z` held; toggle `mode` → `run_len`=0, `z`=0, `event_count` unchanged.
- `EVT_W`=2: 5 pulse-mode detections → `event_count` stops at 3; `clear_events` coincident with a detection → `event_count`=0 while `z` still pulses.
- Assert `reset` during a run of 3 → all outputs 0 next clock; 4 further equal bits are needed for `z`.
